// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries EX write-back results to MEM and keeps the
// multiply-accumulate intermediate product and step counter between EX cycles.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  logic ex_stalled;
  logic mem_stalled;

  assign ex_stalled  = stall[3];
  assign mem_stalled = stall[4];

  // A stalled EX with a running MEM sends a bubble downstream while the
  // accumulator state is kept for the next EX cycle; a fully stalled pair
  // holds the MEM-side fields but still tracks the accumulator from EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd    <= 5'h00;
      mem_wreg  <= 1'b0;
      mem_wdata <= 32'h0;
      mem_hi    <= 32'h0;
      mem_lo    <= 32'h0;
      mem_whilo <= 1'b0;
      hilo_o    <= 64'h0;
      cnt_o     <= 2'b00;
    end else if (flush) begin
      mem_wd    <= 5'h00;
      mem_wreg  <= 1'b0;
      mem_wdata <= 32'h0;
      mem_hi    <= 32'h0;
      mem_lo    <= 32'h0;
      mem_whilo <= 1'b0;
      hilo_o    <= 64'h0;
      cnt_o     <= 2'b00;
    end else if (ex_stalled && !mem_stalled) begin
      mem_wd    <= 5'h00;
      mem_wreg  <= 1'b0;
      mem_wdata <= 32'h0;
      mem_hi    <= 32'h0;
      mem_lo    <= 32'h0;
      mem_whilo <= 1'b0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end else if (!ex_stalled) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo;
      hilo_o    <= 64'h0;
      cnt_o     <= 2'b00;
    end else begin
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end
  end

endmodule
